// File: rtl/bcd_to_bin.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out, one bit per cycle.
// Valid operand finishes BIN_W+1 edges after the accepting edge; a bad digit finishes after one.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [BIN_W-1:0]   bin_q, bin_d;

  logic               digit_bad;
  logic [SR_W-1:0]    sr_shift;

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // Shift first, then pull each BCD field back by 3 where its top bit came set.
  always_comb begin
    sr_shift = sr_q >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_shift[BIN_W + 4*i + 3])
        sr_shift[BIN_W + 4*i +: 4] = sr_shift[BIN_W + 4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          err_d   = digit_bad;
          state_d = digit_bad ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = FINISH;
      end
      FINISH: begin
        bin_d   = err_q ? '0 : sr_q[BIN_W-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = done_q;
    err     = err_q;
    bin_out = bin_q;
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed-vector bench for bcd_to_bin: conversions, bad digits, ignored start,
// asynchronous abort and back-to-back starts.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy, done, err;
  logic [13:0] bin_out;

  int n_checks = 0;
  int n_errors = 0;

  bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called just after the accepting edge; counts edges until done rises.
  task automatic wait_done(input string tag, input int exp_lat, input int prev_bin);
    int n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      check({tag, " busy"}, busy, 1);
      check({tag, " hold"}, bin_out, prev_bin);
    end
    check({tag, " lat"}, n, exp_lat);
  endtask

  task automatic run_conv(input string tag, input logic [15:0] bcd,
                          input int exp_bin, input int exp_err, input int exp_lat);
    int prev;
    prev = bin_out;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = 16'hFFFF;
    check({tag, " busy0"}, busy, 1);
    check({tag, " err0"}, err, exp_err);
    wait_done(tag, exp_lat, prev);
    check({tag, " bin"}, bin_out, exp_bin);
    check({tag, " err"}, err, exp_err);
    check({tag, " busy_done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, " done1"}, done, 0);
    check({tag, " bin_hold"}, bin_out, exp_bin);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check({tag, " no_done"}, seen, 0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = 16'h0000;
    #3;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst bin", bin_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_conv("zero",  16'h0000, 0,    0, 15);
    run_conv("9999",  16'h9999, 9999, 0, 15);
    run_conv("0250",  16'h0250, 250,  0, 15);
    run_conv("1024",  16'h1024, 1024, 0, 15);
    run_conv("bad",   16'h12A4, 0,    1, 1);
    run_conv("after_bad", 16'h0005, 5, 0, 15);

    // Second start mid-conversion must be ignored.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0100;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = 16'hFFFF;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0999;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = 16'hFFFF;
    wait_done("ign", 10, 5);
    check("ign bin", bin_out, 100);
    count_dones("ign", 20);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h4321;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #2;
    reset = 1'b1;
    #1;
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst err", err, 0);
    check("arst bin", bin_out, 0);
    @(negedge clk);
    reset = 1'b0;
    count_dones("arst", 20);
    check("arst idle", busy, 0);
    run_conv("0042", 16'h0042, 42, 0, 15);

    // Start held high: restart on the done cycle with no gap.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0007;
    @(posedge clk); #1;
    wait_done("b2b7", 15, 42);
    check("b2b7 bin", bin_out, 7);
    check("b2b7 busy", busy, 0);
    bcd_in = 16'h0008;
    @(posedge clk); #1;
    check("b2b8 busy0", busy, 1);
    check("b2b8 done_low", done, 0);
    wait_done("b2b8", 15, 7);
    check("b2b8 bin", bin_out, 8);
    check("b2b8 busy", busy, 0);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b8 done1", done, 0);
    check("b2b8 idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential reverse double-dabble converter: packed BCD (keypad-entered price/credit digits) in, unsigned binary out.
- Inverse of the combinational binary-to-BCD display path.
- Sits between the keypad digit accumulator and the credit/price arithmetic in the vending controller.
- One conversion at a time, with a start/busy/done handshake and an invalid-digit error flag.

Parameters:
- DIGITS, 4, number of BCD digits in bcd_in (digit 0 = bits [3:0], least significant).
- BIN_W, 14, binary output width. Must be >= ceil(log2(10^DIGITS)); 14 for 4 digits, since 9999 < 16384.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only when busy=0.
- bcd_in  input  4*DIGITS  packed BCD operand; sampled on the same edge as an accepted start.
- busy  output  1  conversion in progress; start is ignored while high.
- done  output  1  single-cycle completion pulse.
- err  output  1  last accepted operand contained a digit > 9.
- bin_out  output  BIN_W  converted value; holds until the next completion.

Behaviour:
- Reset, asynchronous, active-high: state=IDLE, busy=0, done=0, err=0, bin_out=0, shift register and counter cleared. Reset mid-conversion aborts with no done pulse.
- Datapath: shift register sr of width 4*DIGITS+BIN_W; counter cnt of width ceil(log2(BIN_W+1)).
- State IDLE:
  - On an edge with start=1, the operand is accepted and err is cleared.
  - If any digit of bcd_in is > 9: err<=1, go to FINISH with sr low field = 0.
  - Otherwise: sr <= {bcd_in, BIN_W'b0}, cnt<=0, go to SHIFT.
  - busy=1 from this edge onward.
- State SHIFT, one iteration per edge:
  - sr <= sr >> 1 (zero fill at the MSB).
  - Then, in the same cycle on the shifted value, each 4-bit digit field in the upper 4*DIGITS bits that is >= 8 has 3 subtracted (mod 16).
  - cnt increments. On the edge performing iteration BIN_W (cnt==BIN_W-1 before the edge), go to FINISH.
- State FINISH, one edge:
  - bin_out <= sr[BIN_W-1:0], or 0 when err=1.
  - done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency:
  - Valid operand: done is high in the cycle after edge BIN_W+1, counted from the accepting edge = edge 0 (15 edges for defaults).
  - Invalid operand: done is high after edge 1.
- Busy and start:
  - busy is high from the accepting edge through the FINISH edge; low in the cycle that done is high.
  - start while busy=1 is ignored, and bcd_in is not resampled.
  - start=1 in the done cycle is accepted, so back-to-back conversions incur no idle gap.
- Holding rules:
  - bin_out changes only at a FINISH edge; it is stable while busy.
  - err holds until the next accepted start.
- Width and arithmetic:
  - Result range is 0 to 10^DIGITS-1; no overflow is possible under the BIN_W constraint.
  - The digit correction never underflows for valid input.
  - A start held high continuously restarts a conversion on every done cycle.

Test Plan:
- bcd_in=16'h0000, 1-cycle start -> done after edge 15, bin_out=0, err=0, busy high for edges 0..15.
- bcd_in=16'h9999 -> bin_out=14'd9999; bcd_in=16'h0250 -> 14'd250; bcd_in=16'h1024 -> 14'd1024. Each with done exactly 15 edges after start.
- bcd_in=16'h12A4 -> err=1, bin_out=0, done after edge 1. A following valid start of 16'h0005 clears err at acceptance and yields 5.
- Start 16'h0100, then pulse start with 16'h0999 at edge 5 -> second request ignored, single done, bin_out=100.
- Assert reset at edge 7 of a 16'h4321 conversion -> all outputs 0 immediately (asynchronous), no done pulse. A new start of 16'h0042 yields 42.
- Hold start=1 with bcd_in 16'h0007, then 16'h0008 presented in the done cycle -> outputs 7 then 8, done pulses 15 edges apart, busy low only during the done cycles.
